// File: rtl/dot_prod_pkg.sv
// -----------------------------------------------------------------------------
// dot_prod_pkg
// Shared types and constants for the sequential dot-product controller.
//   state_t  : controller FSM states (IDLE, CLEAR, FEED, WAIT)
//   ADDR_W   : operand memory address / term count width
//   DATA_W   : signed operand width
//   ACC_W    : MAC accumulator / result width
//   SAT_POS  : positive saturation value
//   SAT_NEG  : negative saturation value
// -----------------------------------------------------------------------------
package dot_prod_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    localparam logic [ACC_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [ACC_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/dot_prod_seq.sv
// -----------------------------------------------------------------------------
// dot_prod_seq
// Sequences a signed dot product of two operand memories through an external
// signed 8-bit MAC, then saturates the 16-bit accumulator into a result.
//
// Ports
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_start, i_len        : request a dot product of i_len terms (IDLE only)
//   o_op_addr             : shared read address to the A/B operand memories
//   i_a_rdata, i_b_rdata  : operand data, one-cycle synchronous read latency
//   o_mac_a, o_mac_b      : operands driven to the MAC
//   o_mac_clr_n           : MAC clear, active-low
//   i_mac_acc             : MAC accumulator
//   i_mac_of, i_mac_uf    : MAC per-step overflow/underflow flags
//   o_result, o_sat       : saturated result and saturation indicator
//   o_busy, o_done        : busy level, one-cycle completion pulse
// -----------------------------------------------------------------------------
module dot_prod_seq
    import dot_prod_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_len,
    output logic [ADDR_W-1:0] o_op_addr,
    input  logic [DATA_W-1:0] i_a_rdata,
    input  logic [DATA_W-1:0] i_b_rdata,
    output logic [DATA_W-1:0] o_mac_a,
    output logic [DATA_W-1:0] o_mac_b,
    output logic              o_mac_clr_n,
    input  logic [ACC_W-1:0]  i_mac_acc,
    input  logic              i_mac_of,
    input  logic              i_mac_uf,
    output logic [ACC_W-1:0]  o_result,
    output logic              o_sat,
    output logic              o_busy,
    output logic              o_done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_len;
    logic [ADDR_W-1:0]  r_cnt;
    logic               r_st_of;
    logic               r_st_uf;
    logic [ACC_W-1:0]   r_result;
    logic               r_sat;
    logic               r_done;

    logic               w_accept;
    logic               w_last_term;
    logic               w_flag_en;
    logic               w_flag_free;
    logic               w_st_of;
    logic               w_st_uf;

    assign w_accept    = (r_state == ST_IDLE) && i_start;
    assign w_last_term = (r_cnt == (r_len - ADDR_W'(1)));

    // A MAC flag describes the term retired on the previous edge. In FEED k=0
    // the previous edge was the clear, so only FEED k>=1 and WAIT carry flags.
    assign w_flag_en   = ((r_state == ST_FEED) && (r_cnt != '0)) || (r_state == ST_WAIT);
    assign w_flag_free = !r_st_of && !r_st_uf;

    // First flag wins and locks; overflow beats underflow in the same cycle.
    // These are the post-sample sticky values, so the WAIT decision includes
    // the flag arriving in WAIT itself.
    assign w_st_of = r_st_of | (w_flag_en & w_flag_free & i_mac_of);
    assign w_st_uf = r_st_uf | (w_flag_en & w_flag_free & ~i_mac_of & i_mac_uf);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and MAC/memory drive
    always_comb begin
        w_state_next = r_state;
        o_mac_a      = '0;
        o_mac_b      = '0;
        o_mac_clr_n  = 1'b1;
        o_op_addr    = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Address 0 is issued here so term 0 data arrives in FEED k=0.
                o_mac_clr_n  = 1'b0;
                w_state_next = (r_len != '0) ? ST_FEED : ST_WAIT;
            end
            ST_FEED: begin
                o_mac_a   = i_a_rdata;
                o_mac_b   = i_b_rdata;
                o_op_addr = r_cnt + ADDR_W'(1);
                if (w_last_term) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Term counter, sticky flags, result capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len    <= '0;
            r_cnt    <= '0;
            r_st_of  <= 1'b0;
            r_st_uf  <= 1'b0;
            r_result <= '0;
            r_sat    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len   <= i_len;
                r_cnt   <= '0;
                r_st_of <= 1'b0;
                r_st_uf <= 1'b0;
            end else begin
                if (r_state == ST_FEED) begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                end
                r_st_of <= w_st_of;
                r_st_uf <= w_st_uf;
            end

            r_done <= (r_state == ST_WAIT);

            if (r_state == ST_WAIT) begin
                if (w_st_of) begin
                    r_result <= SAT_POS;
                end else if (w_st_uf) begin
                    r_result <= SAT_NEG;
                end else begin
                    r_result <= i_mac_acc;
                end
                r_sat <= w_st_of | w_st_uf;
            end
        end
    end

    assign o_result = r_result;
    assign o_sat    = r_sat;
    assign o_done   = r_done;
    assign o_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dot_prod_seq.sv
// -----------------------------------------------------------------------------
// tb_dot_prod_seq
// Bench for dot_prod_seq: synchronous operand memories, a signed 8-bit MAC
// with 16-bit wrapping accumulator and per-step overflow flags, and an
// arithmetic reference for the saturated dot product.
// -----------------------------------------------------------------------------
module tb_dot_prod_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  op_addr;
    logic [7:0]  a_rdata;
    logic [7:0]  b_rdata;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_clr_n;
    logic [15:0] mac_acc;
    logic        mac_of;
    logic        mac_uf;
    logic [15:0] result;
    logic        sat;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [7:0] mem_a [256];
    logic signed [7:0] mem_b [256];

    dot_prod_seq u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_len       (len),
        .o_op_addr   (op_addr),
        .i_a_rdata   (a_rdata),
        .i_b_rdata   (b_rdata),
        .o_mac_a     (mac_a),
        .o_mac_b     (mac_b),
        .o_mac_clr_n (mac_clr_n),
        .i_mac_acc   (mac_acc),
        .i_mac_of    (mac_of),
        .i_mac_uf    (mac_uf),
        .o_result    (result),
        .o_sat       (sat),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous operand memories
    always @(posedge clk) begin
        a_rdata <= mem_a[op_addr];
        b_rdata <= mem_b[op_addr];
    end

    // MAC: 16-bit wrapping accumulator, flags on true signed overflow of a step
    int mac_sum;
    assign mac_sum = int'($signed(mac_acc)) + int'($signed(mac_a)) * int'($signed(mac_b));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_acc <= '0;
            mac_of  <= 1'b0;
            mac_uf  <= 1'b0;
        end else if (!mac_clr_n) begin
            mac_acc <= '0;
            mac_of  <= 1'b0;
            mac_uf  <= 1'b0;
        end else begin
            mac_acc <= mac_sum[15:0];
            mac_of  <= (mac_sum > 32767);
            mac_uf  <= (mac_sum < -32768);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: running sum in 16-bit wrap; the first out-of-range step
    // decides the saturation direction.
    task automatic ref_dot(input int n, output logic [15:0] res, output logic s);
        int acc;
        int sum;
        logic [15:0] w;
        bit of;
        bit uf;
        acc = 0;
        of  = 0;
        uf  = 0;
        for (int k = 0; k < n; k++) begin
            sum = acc + int'(mem_a[k]) * int'(mem_b[k]);
            if (!of && !uf) begin
                if (sum > 32767)       of = 1;
                else if (sum < -32768) uf = 1;
            end
            w   = sum[15:0];
            acc = int'($signed(w));
        end
        w   = acc[15:0];
        res = of ? 16'h7FFF : (uf ? 16'h8000 : w);
        s   = of | uf;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'($urandom);
            mem_b[k] = 8'($urandom);
        end
    endtask

    // Called at a negedge with start already raised (sampled at E0). Walks
    // edges E0..E(n+2) checking busy, done and clear; checks result at done.
    // If next_len >= 0 a new start is raised in the done cycle.
    task automatic run_op(input int n, input int repulse_at, input int next_len);
        logic [15:0] exp_res;
        logic        exp_sat;
        int          clr_cnt;
        ref_dot(n, exp_res, exp_sat);
        clr_cnt = 0;
        for (int e = 0; e <= n + 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            start = (e == repulse_at);
            if (e == 0) len = 8'($urandom);
            if (!mac_clr_n) clr_cnt++;
            chk("busy", busy, (e <= n + 1));
            chk("done", done, (e == n + 2));
            if (e == 1 && n > 0) chk("op_addr_k0", op_addr, 1);
            if (e == n + 2) begin
                chk("result", result, exp_res);
                chk("sat", sat, exp_sat);
                chk("clr_cycles", clr_cnt, 1);
                $display("op len=%0d result=%h sat=%0b exp_result=%h exp_sat=%0b",
                         n, result, sat, exp_res, exp_sat);
            end
        end
        if (next_len >= 0) begin
            len   = 8'(next_len);
            start = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("idle_done", done, 0);
                chk("idle_busy", busy, 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        fill_random();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_sat", sat, 0);
        chk("rst_op_addr", op_addr, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        chk("rst_clr_n", mac_clr_n, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: 1*5 + 2*6 + 3*7 + 4*8 = 70
        for (int k = 0; k < 4; k++) begin
            mem_a[k] = 8'(k + 1);
            mem_b[k] = 8'(k + 5);
        end
        len = 8'd4; start = 1'b1;
        run_op(4, -1, -1);
        chk("dir_result_46", result, 16'h0046);

        // Zero-length
        len = 8'd0; start = 1'b1;
        run_op(0, -1, -1);

        // Positive saturation
        for (int k = 0; k < 3; k++) begin
            mem_a[k] = 8'sd127;
            mem_b[k] = 8'sd127;
        end
        len = 8'd3; start = 1'b1;
        run_op(3, -1, -1);
        chk("sat_pos_result", result, 16'h7FFF);

        // Negative saturation
        for (int k = 0; k < 3; k++) mem_a[k] = -8'sd128;
        len = 8'd3; start = 1'b1;
        run_op(3, -1, -1);
        chk("sat_neg_result", result, 16'h8000);

        // Start re-pulsed during FEED, then back-to-back start in done cycle
        fill_random();
        len = 8'd5; start = 1'b1;
        run_op(5, 2, 3);
        run_op(3, -1, -1);

        // Randomized operations, including a full-length one
        for (int t = 0; t < 8; t++) begin
            int n;
            fill_random();
            n = (t == 7) ? 255 : int'($urandom_range(0, 40));
            len = 8'(n); start = 1'b1;
            run_op(n, -1, -1);
        end

        // Reset during FEED k=2 of len=8
        fill_random();
        len = 8'd8; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_op_addr", op_addr, 3);
        chk("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_sat", sat, 0);
        chk("abort_clr_n", mac_clr_n, 1);
        chk("abort_mac_a", mac_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        fill_random();
        len = 8'd2; start = 1'b1;
        run_op(2, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_prod_seq.md
DOT_PROD_SEQ -- requirements
Module: dot_prod_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request a dot product; sampled only in IDLE.
REQ-004 len  input  8  number of terms, 0..255; sampled with an accepted start.
REQ-005 op_addr  output  8  shared read address to the A and B operand memories.
REQ-006 a_rdata, b_rdata  input  8 each  signed operand data; synchronous memories, one-cycle read latency.
REQ-007 mac_a, mac_b  output  8 each  signed operands driven to the downstream signed 8-bit MAC.
REQ-008 mac_clr_n  output  1  MAC clear, active-low.
REQ-009 mac_acc  input  16  MAC accumulator.
REQ-010 mac_of, mac_uf  input  1 each  MAC per-step overflow/underflow flags; each is valid in the cycle after the term edge.
REQ-011 result  output  16  saturated signed dot product.
REQ-012 sat  output  1  result was saturated.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse; result/sat valid from this cycle onward.

Function
REQ-015 FSM states: IDLE, CLEAR, FEED, WAIT.
REQ-016 IDLE->CLEAR on start; CLEAR->FEED if len>0, else WAIT; FEED->WAIT after exactly len cycles; WAIT->IDLE.
REQ-017 Start sampled at edge E0: CLEAR occupies the cycle after E0; FEED occupies the cycles after E1..E(len); WAIT occupies the cycle after E(len+1); done is high in the cycle after E(len+2).
REQ-018 CLEAR: mac_clr_n=0, mac_a=mac_b=0, op_addr=0.
REQ-019 FEED term k (k=0..len-1): mac_a=a_rdata, mac_b=b_rdata, mac_clr_n=1, op_addr=k+1; addresses at or beyond len are don't-care reads.
REQ-020 IDLE and WAIT: mac_a=mac_b=0 and mac_clr_n=1, so the MAC accumulator holds.
REQ-021 Sticky saturation register samples mac_of/mac_uf in FEED cycles k>=1 and in WAIT only.
- Flags are ignored in CLEAR, IDLE and FEED k=0.
REQ-022 Sticky saturation direction: the first flag seen wins and is locked until the next accepted start.
- If of and uf are seen in the same cycle, of wins.
REQ-023 At the WAIT edge, including the flag sampled in WAIT itself:
- result <= 16'h7FFF if sticky of;
- result <= 16'h8000 if sticky uf;
- otherwise result <= mac_acc.
- sat <= 1 if either sticky flag is set; done <= 1.
REQ-024 result and sat hold their values until the next WAIT edge.
REQ-025 Sticky flags and the term counter clear on an accepted start.
REQ-026 start while busy=1 is ignored; len changes while busy have no effect.
REQ-027 start during the done cycle is accepted, because the FSM is already in IDLE: back-to-back operation with no idle gap.
REQ-028 len=0 produces result=0 and sat=0, with done after E2.

Reset
REQ-029 rst_n low, at any time including mid-FEED, forces IDLE immediately.
- Reset values: busy=0, done=0, result=0, sat=0, op_addr=0, counter=0, sticky flags=0.
- Combinational outputs take their IDLE values: mac_a=mac_b=0, mac_clr_n=1.
REQ-030 No done pulse is issued for an operation aborted by reset.

Structure
REQ-031 Package dot_prod_pkg holds:
- the state enum;
- ADDR_W=8 and DATA_W=8;
- SAT_POS=16'h7FFF and SAT_NEG=16'h8000.
REQ-032 No sub-module: counter, sticky logic and FSM are inline; the MAC is a peer instance at the parent level, not inside this block.

Verification
REQ-033 Bench pairs this block with synchronous memory models and a MAC model that flags of/uf on true signed 16-bit overflow.
REQ-034 len=4, A={1,2,3,4}, B={5,6,7,8}, start at E0 -> done after E6, result=16'h0046, sat=0, busy high for cycles after E0..E5.
REQ-035 len=0 -> done after E2, result=0, sat=0, mac_clr_n low exactly one cycle.
REQ-036 len=3, A=B={127,127,127} -> sum 48387 overflows -> result=16'h7FFF, sat=1; A={-128,-128,-128}, B={127,127,127} -> result=16'h8000, sat=1.
REQ-037 start re-pulsed during FEED -> ignored, single done; second start in the done cycle -> accepted, next done len+2 edges later.
REQ-038 rst_n low during FEED k=2 of len=8 -> immediately busy=0, result=0, mac_clr_n=1, no done; subsequent len=2 run completes correctly.
